// File: rtl/wb_sram_pkg.sv
// wb_sram_pkg: shared types, limits and address decode for the Wishbone SRAM responder
package wb_sram_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} wbsram_state_t;
  localparam int unsigned WBSRAM_MAX_WAIT = 15;
  function automatic logic wbsram_addr_ok(input logic [31:0] addr, input logic [31:0] base, input int unsigned depth);
    return addr[1:0] == 2'b00 && addr >= base && {1'b0, addr} < {1'b0, base} + {depth[30:0], 2'b00};
  endfunction
endpackage

// File: rtl/wb_sram_responder_if.sv
// Wishbone: classic Wishbone bus bundle with controller and peripheral views
interface Wishbone;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        ack;
  logic        err;
  modport Peripheral (input cyc, stb, we, sel, addr, data_wr, output data_rd, ack, err);
  modport Controller (output cyc, stb, we, sel, addr, data_wr, input data_rd, ack, err);
endinterface

// File: rtl/wb_sram_responder_sram_1rw_be.sv
// sram_1rw_be: single-port byte-writable RAM with a registered, resettable read port
module sram_1rw_be #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter string       INIT_FILE   = "",
  localparam int         AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  always_ff @(posedge i_clk) begin
    if (i_en && i_we)
      for (int k = 0; k < 4; k++)
        if (i_be[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) o_rdata <= '0;
    else if (i_en && !i_we) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/wb_sram_responder.sv
// wb_sram_responder: classic Wishbone responder in front of a byte-writable SRAM
module wb_sram_responder
  import wb_sram_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input logic         i_clk,
  input logic         i_rst,
  Wishbone.Peripheral wb
);
  localparam int AW = $clog2(DEPTH_WORDS);
  wbsram_state_t r_state, w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_good;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic        w_acc;
  logic        w_fire;
  logic        w_ok;
  logic        w_we;
  logic [3:0]  w_sel;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  assign w_acc = r_state != WAIT && wb.cyc && wb.stb;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  end
  always_comb begin
    w_state_nxt = r_state == WAIT ? (!wb.cyc ? IDLE : r_cnt == 4'd0 ? RESP : WAIT)
                : w_acc ? (WAIT_STATES == 0 ? RESP : WAIT) : IDLE;
  end
  always_comb begin
    wb.ack = r_state == RESP && r_good;
    wb.err = r_state == RESP && !r_good;
  end
  always_ff @(posedge i_clk) begin
    if (w_acc) begin
      r_addr <= wb.addr;
      r_we   <= wb.we;
      r_sel  <= wb.sel;
      r_data <= wb.data_wr;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_good <= 1'b0;
    end else begin
      if (w_acc) r_cnt <= 4'(WAIT_STATES - 1);
      else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_fire) r_good <= w_ok;
    end
  end
  // Zero-wait requests hit the RAM on their accept edge, so decode the live bus outside WAIT
  assign w_addr = r_state == WAIT ? r_addr : wb.addr;
  assign w_we   = r_state == WAIT ? r_we : wb.we;
  assign w_sel  = r_state == WAIT ? r_sel : wb.sel;
  assign w_data = r_state == WAIT ? r_data : wb.data_wr;
  assign w_ok   = wbsram_addr_ok(w_addr, BASE_ADDR, DEPTH_WORDS);
  assign w_fire = w_state_nxt == RESP && !i_rst;
  sram_1rw_be #(.DEPTH_WORDS(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_fire && w_ok),
    .i_we    (w_we),
    .i_be    (w_sel),
    .i_addr  (w_addr[2 +: AW]),
    .i_wdata (w_data),
    .o_rdata (wb.data_rd)
  );
`ifdef VERIFICATION
  logic r_v_hold;
  always_ff @(posedge i_clk) begin
    r_v_hold <= (wb.ack || wb.err) && !w_acc && !i_rst;
    if (wb.ack && wb.err) $error("ack and err asserted together");
    if (r_v_hold && (wb.ack || wb.err)) $error("response held without a new accept");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of two");
  end
  if (WAIT_STATES > WBSRAM_MAX_WAIT) begin : g_bad_wait
    $error("WAIT_STATES out of range");
  end
  if ((BASE_ADDR % (4 * DEPTH_WORDS)) != 0) begin : g_bad_base
    $error("BASE_ADDR not aligned to memory size");
  end
`endif
endmodule

// File: tb/tb_wb_sram_responder.sv
// tb_wb_sram_responder: scoreboard bench over zero, three and two wait-state responders
module tb_wb_sram_responder;
  typedef struct {
    int          cyc;
    bit          err;
    logic [31:0] rd;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  int          dsel = 0;
  int          cyc_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  int          zero_req = 0;
  int          zero_done = 0;
  bit          done = 1'b0;
  logic [2:0]  m_ack;
  logic [2:0]  m_err;
  logic [31:0] m_rd [3];
  exp_t        q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  function automatic int ws(int i);
    return i == 0 ? 0 : (i == 1 ? 3 : 2);
  endfunction
  for (genvar g = 0; g < 3; g++) begin : g_dut
    Wishbone bus ();
    assign bus.cyc     = cyc && dsel == g;
    assign bus.stb     = stb;
    assign bus.we      = we;
    assign bus.sel     = sel;
    assign bus.addr    = addr;
    assign bus.data_wr = wdat;
    assign m_ack[g]    = bus.ack;
    assign m_err[g]    = bus.err;
    assign m_rd[g]     = bus.data_rd;
    wb_sram_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_STATES(ws(g)), .INIT_FILE("")) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .wb    (bus)
    );
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (zero_req != zero_done) begin
      for (int i = 0; i < 3; i++) begin
        chk("reset_ack", 32'(m_ack[i]), 32'd0);
        chk("reset_err", 32'(m_err[i]), 32'd0);
        chk("reset_data_rd", m_rd[i], 32'd0);
      end
      zero_done = zero_req;
    end
    if (!rst && (m_ack[dsel] || m_err[dsel])) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp dut=%0d ack=%0b err=%0b cycle=%0d required=none", dsel, m_ack[dsel], m_err[dsel], cyc_cnt);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", 32'(cyc_cnt), 32'(e.cyc));
        chk("resp_err", 32'(m_err[dsel]), 32'(e.err));
        chk("resp_ack", 32'(m_ack[dsel]), 32'(!e.err));
        chk("data_rd", m_rd[dsel], e.rd);
      end
    end
    if (done) begin
      chk("pending_responses", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    cyc = 1'b0;
    stb = 1'b0;
    repeat (n) tick;
  endtask
  // Returns in the response cycle, so consecutive calls exercise back-to-back accepts
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input bit e_err, input logic [31:0] e_rd);
    q.push_back('{cyc_cnt + 1 + ws(dsel), e_err, e_rd});
    cyc = 1'b1;
    stb = 1'b1;
    we = w;
    addr = a;
    wdat = d;
    sel = s;
    tick;
    stb = 1'b0;
    repeat (ws(dsel)) tick;
  endtask
  task automatic abort(input bit use_rst, input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1;
    stb = 1'b1;
    we = 1'b1;
    addr = a;
    wdat = d;
    sel = 4'hF;
    tick;
    stb = 1'b0;
    if (use_rst) rst = 1'b1;
    else cyc = 1'b0;
    tick;
    rst = 1'b0;
    cyc = 1'b0;
    if (use_rst) zero_req++;
    idle(4);
  endtask
  initial begin
    repeat (3) tick;
    rst = 1'b0;
    zero_req++;
    tick;
    dsel = 0;
    txn(1, 32'h00, 32'hA0A0A0A0, 4'hF, 0, 32'h0);
    txn(1, 32'h04, 32'hB1B1B1B1, 4'hF, 0, 32'h0);
    txn(1, 32'h08, 32'hC2C2C2C2, 4'hF, 0, 32'h0);
    txn(1, 32'h0C, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    idle(1);
    txn(0, 32'h0C, 32'h0, 4'hF, 0, 32'hDEADBEEF);
    idle(1);
    txn(1, 32'h10, 32'h00000000, 4'hF, 0, 32'hDEADBEEF);
    txn(1, 32'h10, 32'h11223344, 4'b0101, 0, 32'hDEADBEEF);
    txn(0, 32'h10, 32'h0, 4'hF, 0, 32'h00220044);
    idle(1);
    txn(0, 32'h0E, 32'h0, 4'hF, 1, 32'h00220044);
    txn(1, 32'h40, 32'hFFFFFFFF, 4'hF, 1, 32'h00220044);
    idle(1);
    stb = 1'b1;
    we = 1'b0;
    addr = 32'h0C;
    tick;
    idle(3);
    txn(0, 32'h00, 32'h0, 4'hF, 0, 32'hA0A0A0A0);
    txn(0, 32'h04, 32'h0, 4'hF, 0, 32'hB1B1B1B1);
    txn(0, 32'h08, 32'h0, 4'hF, 0, 32'hC2C2C2C2);
    idle(1);
    txn(1, 32'h14, 32'h55AA55AA, 4'hF, 0, 32'hC2C2C2C2);
    txn(0, 32'h14, 32'h0, 4'h0, 0, 32'h55AA55AA);
    idle(2);
    dsel = 1;
    txn(1, 32'h0C, 32'hDEADBEEF, 4'hF, 0, 32'h0);
    idle(1);
    txn(0, 32'h0C, 32'h0, 4'hF, 0, 32'hDEADBEEF);
    txn(0, 32'h0E, 32'h0, 4'hF, 1, 32'hDEADBEEF);
    idle(2);
    dsel = 2;
    txn(1, 32'h20, 32'h01020304, 4'hF, 0, 32'h0);
    idle(1);
    abort(0, 32'h20, 32'hCAFEF00D);
    txn(0, 32'h20, 32'h0, 4'hF, 0, 32'h01020304);
    idle(1);
    abort(1, 32'h20, 32'hCAFEF00D);
    txn(0, 32'h20, 32'h0, 4'hF, 0, 32'h01020304);
    idle(3);
    done = 1'b1;
    repeat (5) tick;
  end
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
